// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: one digit lit per slot, dark guard at slot start, per-frame snapshot.
// Latency: outputs registered, one cycle after the edge that samples en; no backpressure, free-running once enabled.
module seg_scan_driver #(
    parameter int DIGIT_CNT   = 3,
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 500,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit DIG_ACT_LOW = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DIGIT_CNT*7-1:0] seg_in,
    input  logic [DIGIT_CNT-1:0]   dp_in,
    output logic [6:0]             seg_out,
    output logic                   dp_out,
    output logic [DIGIT_CNT-1:0]   dig_sel,
    output logic                   frame_done
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = (DIGIT_CNT > 1) ? $clog2(DIGIT_CNT) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_AT  = SW'(BLANK_CYC);
    localparam logic [DW-1:0] DIG_LAST  = DW'(DIGIT_CNT - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                 state, nxt_state;
    logic [SW-1:0]          slot_cnt, nxt_slot;
    logic [DW-1:0]          dig_idx, nxt_dig;
    logic [DIGIT_CNT*7-1:0] snap_seg, nxt_snap_seg;
    logic [DIGIT_CNT-1:0]   snap_dp, nxt_snap_dp;
    logic                   load;

    logic [6:0]             seg_q, seg_n;
    logic                   dp_q, dp_n;
    logic [DIGIT_CNT-1:0]   dig_q, dig_n;
    logic                   fd_q, fd_n;

    always_comb begin
        nxt_state = state;
        nxt_slot  = slot_cnt;
        nxt_dig   = dig_idx;
        load      = 1'b0;
        if (!en) begin
            nxt_state = IDLE;
            nxt_slot  = '0;
            nxt_dig   = '0;
        end else begin
            case (state)
                IDLE: begin
                    nxt_slot  = '0;
                    nxt_dig   = '0;
                    load      = 1'b1;
                    nxt_state = (BLANK_CYC == 0) ? SHOW : BLANK;
                end
                BLANK, SHOW: begin
                    if (slot_cnt == SLOT_LAST) begin
                        nxt_slot  = '0;
                        nxt_state = (BLANK_CYC == 0) ? SHOW : BLANK;
                        if (dig_idx == DIG_LAST) begin
                            nxt_dig = '0;
                            load    = 1'b1;
                        end else begin
                            nxt_dig = dig_idx + DW'(1);
                        end
                    end else begin
                        nxt_slot = slot_cnt + SW'(1);
                        if (state == BLANK && nxt_slot == BLANK_AT)
                            nxt_state = SHOW;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    // Outputs are derived from next-state values so they register in step with the state they describe.
    always_comb begin
        nxt_snap_seg = load ? seg_in : snap_seg;
        nxt_snap_dp  = load ? dp_in  : snap_dp;
        seg_n = '0;
        dp_n  = 1'b0;
        dig_n = '0;
        for (int i = 0; i < DIGIT_CNT; i++) begin
            if (nxt_state == SHOW && nxt_dig == DW'(i)) begin
                seg_n    = nxt_snap_seg[i*7 +: 7];
                dp_n     = nxt_snap_dp[i];
                dig_n[i] = 1'b1;
            end
        end
        fd_n = (nxt_state != IDLE) && (nxt_slot == SLOT_LAST) && (nxt_dig == DIG_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            slot_cnt <= '0;
            dig_idx  <= '0;
            snap_seg <= '0;
            snap_dp  <= '0;
            seg_q    <= '0;
            dp_q     <= 1'b0;
            dig_q    <= '0;
            fd_q     <= 1'b0;
        end else begin
            state    <= nxt_state;
            slot_cnt <= nxt_slot;
            dig_idx  <= nxt_dig;
            snap_seg <= nxt_snap_seg;
            snap_dp  <= nxt_snap_dp;
            seg_q    <= seg_n;
            dp_q     <= dp_n;
            dig_q    <= dig_n;
            fd_q     <= fd_n;
        end
    end

    assign seg_out    = seg_q ^ {7{SEG_ACT_LOW}};
    assign dp_out     = dp_q ^ SEG_ACT_LOW;
    assign dig_sel    = dig_q ^ {DIGIT_CNT{DIG_ACT_LOW}};
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: active-high and active-low instances driven in parallel against a frame-timing model.
module tb_seg_scan_driver;

    localparam int D = 3;
    localparam int S = 8;
    localparam int B = 2;
    localparam int F = D * S;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [20:0] seg_in;
    logic [2:0]  dp_in;
    bit          clk_run = 1'b0;

    logic [6:0] h_seg, l_seg;
    logic       h_dp, l_dp, h_fd, l_fd;
    logic [2:0] h_dig, l_dig;
    logic [11:0] hi_v, lo_v;

    assign hi_v = {h_seg, h_dp, h_dig, h_fd};
    assign lo_v = {l_seg, l_dp, l_dig, l_fd};

    seg_scan_driver #(.DIGIT_CNT(D), .SCAN_DIV(S), .BLANK_CYC(B),
                      .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .dp_in(dp_in),
        .seg_out(h_seg), .dp_out(h_dp), .dig_sel(h_dig), .frame_done(h_fd));

    seg_scan_driver #(.DIGIT_CNT(D), .SCAN_DIV(S), .BLANK_CYC(B),
                      .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .dp_in(dp_in),
        .seg_out(l_seg), .dp_out(l_dp), .dig_sel(l_dig), .frame_done(l_fd));

    always #5 if (clk_run) clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s @%0t: got {seg,dp,dig,fd}=%h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: time since enable, and the frame snapshot taken at each frame start.
    bit          running = 1'b0;
    int          t = 0;
    logic [20:0] m_seg = '0;
    logic [2:0]  m_dp = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            running = 1'b0;
        end else if (!en) begin
            running = 1'b0;
        end else if (!running) begin
            running = 1'b1;
            t = 0;
            m_seg = seg_in;
            m_dp = dp_in;
        end else begin
            t = t + 1;
            if (t % F == 0) begin
                m_seg = seg_in;
                m_dp = dp_in;
            end
        end
    end

    always @(negedge clk) begin
        logic [11:0] e;
        int slot, d;
        e = '0;
        if (running) begin
            slot = t % S;
            d = (t / S) % D;
            if (slot >= B) begin
                e[11:5] = m_seg[d*7 +: 7];
                e[4] = m_dp[d];
                e[1 + d] = 1'b1;
            end
            e[0] = ((t % F) == F - 1);
        end
        chk("model_hi", hi_v, e);
        chk("model_lo", lo_v, e ^ 12'hFFE);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        seg_in = {7'h5B, 7'h06, 7'h3F};
        dp_in  = 3'b010;
        #3;
        chk("reset_hi", hi_v, 12'h000);
        chk("reset_lo", lo_v, {7'h7F, 1'b1, 3'b111, 1'b0});
        clk_run = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("idle_hi", hi_v, 12'h000);

        en = 1'b1;
        cyc = -1;
        tick();
        chk("c0_dark", hi_v, 12'h000);
        run_to(1);
        chk("c1_dark", hi_v, 12'h000);
        run_to(2);
        chk("c2_dig0_hi", hi_v, {7'h3F, 1'b0, 3'b001, 1'b0});
        chk("c2_dig0_lo", lo_v, {7'h40, 1'b1, 3'b110, 1'b0});
        run_to(8);
        chk("c8_dark", hi_v, 12'h000);
        run_to(10);
        chk("c10_dig1", hi_v, {7'h06, 1'b1, 3'b010, 1'b0});
        run_to(12);
        seg_in[6:0] = 7'h7F;
        run_to(18);
        chk("c18_dig2", hi_v, {7'h5B, 1'b0, 3'b100, 1'b0});
        run_to(22);
        chk("c22_no_fd", hi_v, {7'h5B, 1'b0, 3'b100, 1'b0});
        run_to(23);
        chk("c23_fd", hi_v, {7'h5B, 1'b0, 3'b100, 1'b1});
        run_to(24);
        chk("c24_dark", hi_v, 12'h000);
        run_to(26);
        chk("c26_new_snap", hi_v, {7'h7F, 1'b0, 3'b001, 1'b0});

        run_to(29);
        en = 1'b0;
        tick();
        chk("disable_dark_hi", hi_v, 12'h000);
        chk("disable_dark_lo", lo_v, {7'h7F, 1'b1, 3'b111, 1'b0});
        tick();
        tick();
        en = 1'b1;
        cyc = -1;
        run_to(1);
        chk("reen_c1_dark", hi_v, 12'h000);
        run_to(2);
        chk("reen_c2_dig0", hi_v, {7'h7F, 1'b0, 3'b001, 1'b0});

        run_to(4);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hi", hi_v, 12'h000);
        chk("arst_lo", lo_v, {7'h7F, 1'b1, 3'b111, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = -1;
        run_to(1);
        chk("post_rst_c1", hi_v, 12'h000);
        run_to(2);
        chk("post_rst_c2", hi_v, {7'h7F, 1'b0, 3'b001, 1'b0});
        run_to(10);
        chk("post_rst_c10", hi_v, {7'h06, 1'b1, 3'b010, 1'b0});
        run_to(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
